// File: rtl/video_timing_pkg.sv
// mapache64 shared constants.
// Holds the game raster size and the default 640x480@60 VGA timing that
// video_timing and video_axis_counter use as their parameter defaults.
package mapache64;

  localparam int GameWidth  = 256;
  localparam int GameHeight = 240;

  localparam int VgaHVisible = 640;
  localparam int VgaHFront   = 16;
  localparam int VgaHSync    = 96;
  localparam int VgaHBack    = 48;

  localparam int VgaVVisible = 480;
  localparam int VgaVFront   = 10;
  localparam int VgaVSync    = 2;
  localparam int VgaVBack    = 33;

  // Centres the 2x-doubled game raster in the visible line.
  localparam int VgaHBorder  = (VgaHVisible - 2 * GameWidth) / 2;

  // Width of both scan counters; covers 800 columns and 525 lines.
  localparam int CountW      = 10;

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one axis (horizontal or vertical) of the raster scan.
// Ports:
//   clk_i      pixel clock
//   rst_i      asynchronous active-high reset, count returns to 0
//   advance_i  step the count on the next edge
//   count_d_o  value the count takes after the next edge
//   last_d_o   count_d_o is the final position of the axis
//   wrap_o     the count goes back to 0 on the next edge
//   sync_n_o   registered sync for the current position, active low
//   blank_o    registered, high while the current position is not visible
module video_axis_counter
  import mapache64::*;
#(
  parameter int VISIBLE = VgaHVisible,
  parameter int FRONT   = VgaHFront,
  parameter int SYNC    = VgaHSync,
  parameter int BACK    = VgaHBack
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
  output logic [CountW-1:0] count_d_o,
  output logic              last_d_o,
  output logic              wrap_o,
  output logic              sync_n_o,
  output logic              blank_o
);

  localparam int Total = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CountW-1:0] Last   = CountW'(Total - 1);
  localparam logic [CountW-1:0] SyncLo = CountW'(VISIBLE + FRONT);
  localparam logic [CountW-1:0] SyncHi = CountW'(VISIBLE + FRONT + SYNC);
  localparam logic [CountW-1:0] VisEnd = CountW'(VISIBLE);

  logic [CountW-1:0] count_q, count_d;
  logic              sync_n_q, sync_n_d;
  logic              blank_q, blank_d;

  assign wrap_o = advance_i && (count_q == Last);

  // Decodes are taken from the next count so the registered flags line up
  // with count_q rather than trailing it by a cycle.
  always_comb begin
    count_d = count_q;
    if (wrap_o) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = count_q + CountW'(1);
    end
    sync_n_d = !((count_d >= SyncLo) && (count_d < SyncHi));
    blank_d  = (count_d >= VisEnd);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      blank_q  <= blank_d;
    end
  end

  assign count_d_o = count_d;
  assign last_d_o  = (count_d == Last);
  assign sync_n_o  = sync_n_q;
  assign blank_o   = blank_q;

endmodule

// File: rtl/video_timing.sv
// video_timing: 640x480@60 VGA scan generator mapped onto the 256x240 game
// raster (2x pixel doubling, horizontally centred).
// Ports:
//   gpu_clk        pixel clock (25.175 MHz)
//   rst            asynchronous active-high reset, scan returns to (0,0)
//   hsync, vsync   active-low syncs
//   vblank         high on lines >= V_VISIBLE
//   vblank_start   one-cycle pulse at (0, V_VISIBLE)
//   in_game        current pixel is inside the 512x480 game area
//   current_x/y    game coordinates of the current pixel (8'hFF outside)
//   next_x/y       game coordinates of the next pixel in scan order (9'h1FF outside)
// Every output is registered from the counters' next values, so all of them
// describe the same (h, v) as the counter registers.
module video_timing
  import mapache64::*;
#(
  parameter int H_VISIBLE = VgaHVisible,
  parameter int H_FRONT   = VgaHFront,
  parameter int H_SYNC    = VgaHSync,
  parameter int H_BACK    = VgaHBack,
  parameter int V_VISIBLE = VgaVVisible,
  parameter int V_FRONT   = VgaVFront,
  parameter int V_SYNC    = VgaVSync,
  parameter int V_BACK    = VgaVBack,
  parameter int H_BORDER  = VgaHBorder
) (
  input  logic       gpu_clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank,
  output logic       vblank_start,
  output logic       in_game,
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y
);

  localparam logic [CountW-1:0] GameLo = CountW'(H_BORDER);
  localparam logic [CountW-1:0] GameHi = CountW'(H_BORDER + 2 * GameWidth);
  localparam logic [CountW-1:0] VisEnd = CountW'(V_VISIBLE);

  function automatic logic h_in_game(input logic [CountW-1:0] h);
    return (h >= GameLo) && (h < GameHi);
  endfunction

  function automatic logic [7:0] game_x(input logic [CountW-1:0] h);
    return 8'((h - GameLo) >> 1);
  endfunction

  logic [CountW-1:0] h_d, v_d, h_s, v_s;
  logic h_wrap, h_last_d, v_last_d;
  logic v_wrap_unused, h_blank_unused;

  video_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk_i(gpu_clk), .rst_i(rst), .advance_i(1'b1),
    .count_d_o(h_d), .last_d_o(h_last_d), .wrap_o(h_wrap),
    .sync_n_o(hsync), .blank_o(h_blank_unused)
  );

  video_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk_i(gpu_clk), .rst_i(rst), .advance_i(h_wrap),
    .count_d_o(v_d), .last_d_o(v_last_d), .wrap_o(v_wrap_unused),
    .sync_n_o(vsync), .blank_o(vblank)
  );

  logic       in_game_q, in_game_d;
  logic       vbs_q, vbs_d;
  logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [8:0] nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;

  always_comb begin
    // (h_s, v_s) is the successor of the pixel about to be loaded, so the
    // lookahead registers stay one pixel ahead of the current_* registers.
    h_s = h_d + CountW'(1);
    v_s = v_d;
    if (h_last_d) begin
      h_s = '0;
      v_s = v_last_d ? '0 : v_d + CountW'(1);
    end

    in_game_d = h_in_game(h_d) && (v_d < VisEnd);
    cur_x_d   = in_game_d ? game_x(h_d) : 8'hFF;
    cur_y_d   = (v_d < VisEnd) ? 8'(v_d >> 1) : 8'hFF;
    nxt_x_d   = (h_in_game(h_s) && (v_s < VisEnd)) ? {1'b0, game_x(h_s)} : 9'h1FF;
    nxt_y_d   = (v_s < VisEnd) ? {1'b0, 8'(v_s >> 1)} : 9'h1FF;
    vbs_d     = (h_d == '0) && (v_d == VisEnd);
  end

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      in_game_q <= 1'b0;
      vbs_q     <= 1'b0;
      cur_x_q   <= 8'hFF;
      cur_y_q   <= 8'h00;
      nxt_x_q   <= 9'h1FF;
      nxt_y_q   <= 9'h000;
    end else begin
      in_game_q <= in_game_d;
      vbs_q     <= vbs_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      nxt_x_q   <= nxt_x_d;
      nxt_y_q   <= nxt_y_d;
    end
  end

  assign in_game      = in_game_q;
  assign vblank_start = vbs_q;
  assign current_x    = cur_x_q;
  assign current_y    = cur_y_q;
  assign next_x       = nxt_x_q;
  assign next_y       = nxt_y_q;

endmodule
